wb_dsp_bus_arbiter: RTL and testbench
=====================================

# wb_dsp_bus_arbiter

Two-master Wishbone arbiter that sits directly downstream of the equations container. It merges the equation-engine master bus (m0) and the host/control master bus (m1) onto the single DSP memory bus. Arbitration is round-robin and locks on `cyc`. A watchdog terminates any strobe the slave never answers, so a hung equation cannot stall the system.

## Interface
Parameters:
- `aw`, 32, address width
- `dw`, 32, data width
- `TIMEOUT`, 255, cycles of unanswered `stb` before a forced error; 0 disables the watchdog

Ports:
- `wb_clk`  in  1  bus clock, all logic on rising edge
- `wb_rst_n`  in  1  asynchronous, active-low reset
- `m0_adr_i`/`m0_dat_i`/`m0_sel_i`/`m0_we_i`/`m0_cyc_i`/`m0_stb_i`  in  aw/dw/4/1/1/1  equation master request (`eq_*` bus)
- `m0_dat_o`/`m0_ack_o`/`m0_err_o`/`m0_rty_o`  out  dw/1/1/1  equation master response
- `m1_adr_i`/`m1_dat_i`/`m1_sel_i`/`m1_we_i`/`m1_cyc_i`/`m1_stb_i`  in  aw/dw/4/1/1/1  host master request
- `m1_dat_o`/`m1_ack_o`/`m1_err_o`/`m1_rty_o`  out  dw/1/1/1  host master response
- `wb_adr_o`/`wb_dat_o`/`wb_sel_o`/`wb_we_o`/`wb_cyc_o`/`wb_stb_o`  out  aw/dw/4/1/1/1  slave-side request
- `wb_cti_o`/`wb_bte_o`  out  3/2  tied to 0 (classic cycles only)
- `wb_dat_i`/`wb_ack_i`/`wb_err_i`/`wb_rty_i`  in  dw/1/1/1  slave response
- `grant_o`  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, GRANT0, GRANT1. The registered `last` bit records the most recent owner; reset value is 1, so m0 wins the first tie.
- IDLE:
  - Exactly one `mX_cyc_i` high → GRANTx.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- GRANTx:
  - Stay while `mX_cyc_i` is high.
  - When it drops and the other master's `cyc` is high → go directly to the other GRANT (no idle cycle) and update `last`.
  - Otherwise → IDLE.
- Slave outputs are a mux of the owner's signals, gated by state. In IDLE every `wb_*_o` is 0. Equation blocks likewise drive zeros when inactive.
- `wb_dat_i` is broadcast to both `mX_dat_o`. The `ack`/`err`/`rty` responses go only to the owner; the non-owner's responses are always 0.
- A non-owner's `stb` is ignored; it waits with `cyc` held.
- Watchdog (sub-module):
  - The counter, of width clog2(TIMEOUT+1), increments each cycle that `wb_stb_o` is high and no `ack`/`err`/`rty` arrives.
  - It clears on any response, on `stb` low, or on a grant change.
  - When the counter equals TIMEOUT−1 and there is still no response, a registered `to_err` asserts for the next cycle. During that cycle: `mX_err_o` = 1 for the owner, `wb_stb_o` is forced 0, `timeout_o` = 1, and the counter clears.
  - If the slave responds in the same cycle `to_err` would set, the slave response wins and the timeout is suppressed.
- Reset (async, any time): state IDLE, `last` = 1, counter 0, `to_err` 0. All outputs 0 immediately, including mid-transfer.

## Timing
- Grant latency from IDLE is 1 cycle: `cyc` sampled high at edge n gives `grant_o`/`wb_cyc_o` high after edge n.
- Handoff: owner `cyc` low at edge n gives the new owner on the bus after edge n, with zero dead cycles.
- The request and response paths are combinational through the mux: a slave `ack` in cycle k appears as `mX_ack_o` in cycle k.
- Timeout: with `stb` first high in cycle 0 and no response, `mX_err_o`/`timeout_o` pulse in cycle TIMEOUT.
- TIMEOUT = 0: the counter never fires.

## Structure
- Package `wb_dsp_arb_pkg`: state encoding constants (IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10) and the default TIMEOUT.
- Sub-module `wb_dsp_bus_timeout`: counter plus `to_err` register, with inputs `stb`, `resp`, `clr`. The arbiter top holds the FSM, the `last` bit and the muxes.

## Test plan
- m0 only, `cyc`/`stb` high, slave acks 2 cycles later → `grant_o` = 01 one cycle after request; `m0_ack_o` = 1 in the ack cycle; `m1_ack_o` = 0 throughout.
- Both request in the same cycle after reset → m0 granted first. m0 drops `cyc` → m1 granted the next cycle with no idle gap; `wb_adr_o` switches to `m1_adr_i`.
- Both hold `cyc` across repeated single transfers → grants alternate 01, 10, 01.
- TIMEOUT = 4, m1 strobes, slave silent → `m1_err_o` and `timeout_o` pulse in cycle 4; `wb_stb_o` = 0 in that cycle.
- TIMEOUT = 4, slave `ack` lands in cycle 3 → no `err`, no `timeout_o`.
- `wb_rst_n` pulled low mid-transfer in GRANT1 → all outputs 0 asynchronously. After release, a simultaneous request grants m0.

Source files
------------

// File: rtl/wb_dsp_arb_pkg.sv
// Shared definitions for the DSP bus arbiter slice:
// FSM state encoding (doubles as the one-hot grant) and the default watchdog limit.
package wb_dsp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_dsp_bus_timeout.sv
// Strobe watchdog: counts cycles of unanswered stb and raises a one-cycle to_err.
// Ports: clk/rst_n, stb (bus strobe), resp (ack|err|rty), clr (grant change), to_err.
module wb_dsp_bus_timeout
    import wb_dsp_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic resp,
    input  logic clr,
    output logic to_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_err_q, to_err_d;

    always_comb begin
        cnt_d    = cnt_q;
        to_err_d = 1'b0;
        if (TIMEOUT == 0) begin
            cnt_d = '0;
        end else if (to_err_q || clr || !stb || resp) begin
            // a response arriving on the final count wins over the timeout
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            to_err_d = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign to_err = to_err_q;

endmodule

// File: rtl/wb_dsp_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = equation engine, m1 = host) onto the DSP bus.
// Ports: m0_*/m1_* master sides, wb_* slave side, grant_o one-hot owner, timeout_o watchdog pulse.
module wb_dsp_bus_arbiter
    import wb_dsp_arb_pkg::*;
#(
    parameter int aw      = 32,
    parameter int dw      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,
    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       to_err;
    logic       own0, own1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GRANT0 : GRANT1;
                else if (m0_cyc_i)        state_d = GRANT0;
                else if (m1_cyc_i)        state_d = GRANT1;
            end
            GRANT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GRANT1 : IDLE;
            GRANT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GRANT0 : IDLE;
            default: state_d = IDLE;
        endcase
        last_d = last_q;
        if (state_d == GRANT0) last_d = 1'b0;
        if (state_d == GRANT1) last_d = 1'b1;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign own0 = (state_q == GRANT0);
    assign own1 = (state_q == GRANT1);

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        wb_we_o  = 1'b0;
        wb_stb_o = 1'b0;
        if (own0) begin
            wb_adr_o = m0_adr_i;
            wb_dat_o = m0_dat_i;
            wb_sel_o = m0_sel_i;
            wb_we_o  = m0_we_i;
            wb_stb_o = m0_stb_i & ~to_err;
        end else if (own1) begin
            wb_adr_o = m1_adr_i;
            wb_dat_o = m1_dat_i;
            wb_sel_o = m1_sel_i;
            wb_we_o  = m1_we_i;
            wb_stb_o = m1_stb_i & ~to_err;
        end
    end

    assign wb_cyc_o  = own0 | own1;
    assign wb_cti_o  = '0;
    assign wb_bte_o  = '0;
    assign grant_o   = state_q;
    assign timeout_o = to_err;

    // read data is broadcast, but held at zero while reset is asserted
    assign m0_dat_o = wb_rst_n ? wb_dat_i : '0;
    assign m1_dat_o = wb_rst_n ? wb_dat_i : '0;

    assign m0_ack_o = own0 & wb_ack_i;
    assign m0_err_o = own0 & (wb_err_i | to_err);
    assign m0_rty_o = own0 & wb_rty_i;
    assign m1_ack_o = own1 & wb_ack_i;
    assign m1_err_o = own1 & (wb_err_i | to_err);
    assign m1_rty_o = own1 & wb_rty_i;

    wb_dsp_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (wb_clk),
        .rst_n  (wb_rst_n),
        .stb    (wb_stb_o),
        .resp   (wb_ack_i | wb_err_i | wb_rty_i),
        .clr    (state_d != state_q),
        .to_err (to_err)
    );

endmodule

// File: tb/tb_wb_dsp_bus_arbiter.sv
// Self-checking bench for wb_dsp_bus_arbiter (TIMEOUT = 4).
// Table of per-cycle vectors plus hand sequences for handoff, alternation and async reset.
module tb_wb_dsp_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic          m0_we_i, m0_cyc_i, m0_stb_i;
    logic          m1_we_i, m1_cyc_i, m1_stb_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i, wb_err_i, wb_rty_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wb_clk = ~wb_clk;

    wb_dsp_bus_arbiter #(
        .aw      (AW),
        .dw      (DW),
        .TIMEOUT (4)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_sel_i  (m0_sel_i),
        .m0_we_i   (m0_we_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m0_rty_o  (m0_rty_o),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_sel_i  (m1_sel_i),
        .m1_we_i   (m1_we_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .m1_rty_o  (m1_rty_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cti_o  (wb_cti_o),
        .wb_bte_o  (wb_bte_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    // inputs: m0c m0s m1c m1s ack err rty | expected: grant, stb a0 a1 e0 e1 to
    typedef struct packed {
        logic [6:0] in;
        logic [1:0] g;
        logic [5:0] out;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic reset_dut();
        wb_rst_n = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        wb_dat_i = '0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_adr;
        m0_adr_i = A0; m0_dat_i = 32'hD0D0_0000; m0_sel_i = 4'hF; m0_we_i = 1'b1;
        m1_adr_i = A1; m1_dat_i = 32'hD1D1_0000; m1_sel_i = 4'h3; m1_we_i = 1'b0;

        tbl[0]  = {7'b1100000, 2'b00, 6'b000000};
        tbl[1]  = {7'b1100000, 2'b01, 6'b100000};
        tbl[2]  = {7'b1100000, 2'b01, 6'b100000};
        tbl[3]  = {7'b1100100, 2'b01, 6'b110000};
        tbl[4]  = {7'b0011000, 2'b01, 6'b000000};
        tbl[5]  = {7'b0011000, 2'b10, 6'b100000};
        tbl[6]  = {7'b0011000, 2'b10, 6'b100000};
        tbl[7]  = {7'b0011000, 2'b10, 6'b100000};
        tbl[8]  = {7'b0011000, 2'b10, 6'b100000};
        tbl[9]  = {7'b0011000, 2'b10, 6'b000011};
        tbl[10] = {7'b0011000, 2'b10, 6'b100000};
        tbl[11] = {7'b0011000, 2'b10, 6'b100000};
        tbl[12] = {7'b0011000, 2'b10, 6'b100000};
        tbl[13] = {7'b0011100, 2'b10, 6'b101000};
        tbl[14] = {7'b0000000, 2'b10, 6'b000000};
        tbl[15] = {7'b0000011, 2'b00, 6'b000000};

        reset_dut();
        chk("reset_grant", 0, 32'(grant_o), 32'd0);
        chk("reset_cyc", 0, 32'(wb_cyc_o), 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge wb_clk);
            {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i,
             wb_ack_i, wb_err_i, wb_rty_i} = tbl[i].in;
            wb_dat_i = 32'h1000 + 32'(i);
            #1;
            exp_adr = (tbl[i].g == 2'b01) ? A0 : (tbl[i].g == 2'b10) ? A1 : 32'd0;
            chk("grant", i, 32'(grant_o), 32'(tbl[i].g));
            chk("wb_cyc", i, 32'(wb_cyc_o), 32'(tbl[i].g != 2'b00));
            chk("wb_adr", i, wb_adr_o, exp_adr);
            chk("wb_stb", i, 32'(wb_stb_o), 32'(tbl[i].out[5]));
            chk("m0_ack", i, 32'(m0_ack_o), 32'(tbl[i].out[4]));
            chk("m1_ack", i, 32'(m1_ack_o), 32'(tbl[i].out[3]));
            chk("m0_err", i, 32'(m0_err_o), 32'(tbl[i].out[2]));
            chk("m1_err", i, 32'(m1_err_o), 32'(tbl[i].out[1]));
            chk("timeout", i, 32'(timeout_o), 32'(tbl[i].out[0]));
            chk("rty", i, 32'({m0_rty_o, m1_rty_o}), 32'd0);
            chk("m1_dat", i, m1_dat_o, 32'h1000 + 32'(i));
        end

        // simultaneous request after reset, zero-gap handoff, alternation
        reset_dut();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        #1 chk("rr_idle", 0, 32'(grant_o), 32'd0);
        @(negedge wb_clk); #1;
        chk("rr_grant", 1, 32'(grant_o), 32'b01);
        chk("rr_adr", 1, wb_adr_o, A0);
        @(negedge wb_clk);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1 chk("rr_grant", 2, 32'(grant_o), 32'b01);
        @(negedge wb_clk);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        chk("rr_grant", 3, 32'(grant_o), 32'b10);
        chk("rr_adr", 3, wb_adr_o, A1);
        chk("rr_stb", 3, 32'(wb_stb_o), 32'd1);
        @(negedge wb_clk);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1 chk("rr_grant", 4, 32'(grant_o), 32'b10);
        @(negedge wb_clk);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        wb_ack_i = 1'b1;
        #1;
        chk("rr_grant", 5, 32'(grant_o), 32'b01);
        chk("rr_adr", 5, wb_adr_o, A0);
        chk("rr_ack0", 5, 32'(m0_ack_o), 32'd1);
        chk("rr_ack1", 5, 32'(m1_ack_o), 32'd0);
        @(negedge wb_clk);
        wb_ack_i = 1'b0;

        // async reset mid-transfer in GRANT1
        reset_dut();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        @(negedge wb_clk); #1;
        chk("ar_grant", 0, 32'(grant_o), 32'b10);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_FFFF;
        #1 chk("ar_pre_ack", 0, 32'(m1_ack_o), 32'd1);
        wb_rst_n = 1'b0;
        #1;
        chk("ar_grant", 1, 32'(grant_o), 32'd0);
        chk("ar_cyc", 1, 32'(wb_cyc_o), 32'd0);
        chk("ar_stb", 1, 32'(wb_stb_o), 32'd0);
        chk("ar_adr", 1, wb_adr_o, 32'd0);
        chk("ar_wdat", 1, wb_dat_o, 32'd0);
        chk("ar_ack", 1, 32'(m1_ack_o), 32'd0);
        chk("ar_dat", 1, m1_dat_o, 32'd0);
        @(negedge wb_clk);
        wb_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        wb_rst_n = 1'b1;
        @(negedge wb_clk); #1;
        chk("ar_regrant", 2, 32'(grant_o), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
